// File: rtl/button_pulse_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : button_pulse_sync                                          |
// | Description : Multi-channel push-button conditioner. Each channel has a  |
// |               metastability synchronizer, a consecutive-sample debounce  |
// |               filter, a one-cycle press pulse and a debounced level.     |
// |               Channels re-arm after a debounced release (REARM=1), or    |
// |               lock after their first pulse until reset (REARM=0).        |
// | Revision    : 1.0 - initial multi-channel release                        |
// +--------------------------------------------------------------------------+
module button_pulse_sync #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit REARM           = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_async,
  output logic [NUM_CH-1:0] btn_pulse,
  output logic [NUM_CH-1:0] btn_level,
  output logic              any_pulse
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Raw input level that means "not pressed"; synchronizers reset to it so
  // that no phantom press appears after reset.
  localparam logic             IDLE_RAW = ACTIVE_LOW;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_PULSE    = 3'd2,
    ST_HELD     = 3'd3,
    ST_REL_DB   = 3'd4,
    ST_LOCKED   = 3'd5
  } state_t;

  // Next-cycle output values per channel; registered together below so the
  // outputs come straight from flops and any_pulse lines up with btn_pulse.
  logic [NUM_CH-1:0] pulse_nxt;
  logic [NUM_CH-1:0] level_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    // Shift the raw asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{IDLE_RAW}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_async[g]};
      end
    end

    assign pressed = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // Debounce FSM state and stable-sample counter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next-state logic: a press or release is accepted only after the
    // counter has seen DEBOUNCE_CYCLES further agreeing samples.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        ST_IDLE: begin
          if (pressed) begin
            state_d = ST_PRESS_DB;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        ST_PRESS_DB: begin
          if (!pressed) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_PULSE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        ST_PULSE: begin
          state_d = REARM ? ST_HELD : ST_LOCKED;
          cnt_d   = '0;
        end
        ST_HELD: begin
          if (!pressed) begin
            state_d = ST_REL_DB;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        ST_REL_DB: begin
          if (pressed) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        ST_LOCKED: begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign pulse_nxt[g] = (state_d == ST_PULSE);
    assign level_nxt[g] = (state_d == ST_PULSE) || (state_d == ST_HELD) ||
                          (state_d == ST_REL_DB);

`ifndef SYNTHESIS
    // The counter is cleared on every exit path, so it never passes its limit.
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_MAX);
`endif
  end

  // Register the decoded outputs alongside the state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_pulse <= '0;
      btn_level <= '0;
      any_pulse <= 1'b0;
    end else begin
      btn_pulse <= pulse_nxt;
      btn_level <= level_nxt;
      any_pulse <= |pulse_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_pulse_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_button_pulse_sync                                       |
// | Description : Self-checking bench for button_pulse_sync. Three instances |
// |               share one "pressed" stimulus: default (active-low, re-arm),|
// |               legacy one-shot, and active-high polarity.                 |
// | Revision    : 1.0 - initial bench                                        |
// +--------------------------------------------------------------------------+
module tb_button_pulse_sync;

  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int DB  = 16;
  localparam int LAT = SS + DB;

  localparam int M_REL  = 0;
  localparam int M_PUL  = 1;
  localparam int M_HELD = 2;
  localparam int M_LOCK = 3;

  logic clk;
  logic rst;
  logic [NCH-1:0] prs;

  logic [NCH-1:0] pm, lm, pl, ll, pa, la;
  logic           am, al, aa;
  logic [NCH-1:0] btn_lo, btn_hi;

  assign btn_lo = ~prs;
  assign btn_hi = prs;

  button_pulse_sync #(.NUM_CH(NCH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
                      .ACTIVE_LOW(1'b1), .REARM(1'b1)) dut_main (
    .clk(clk), .rst(rst), .btn_async(btn_lo),
    .btn_pulse(pm), .btn_level(lm), .any_pulse(am));

  button_pulse_sync #(.NUM_CH(NCH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
                      .ACTIVE_LOW(1'b1), .REARM(1'b0)) dut_lg (
    .clk(clk), .rst(rst), .btn_async(btn_lo),
    .btn_pulse(pl), .btn_level(ll), .any_pulse(al));

  button_pulse_sync #(.NUM_CH(NCH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
                      .ACTIVE_LOW(1'b0), .REARM(1'b1)) dut_ah (
    .clk(clk), .rst(rst), .btn_async(btn_hi),
    .btn_pulse(pa), .btn_level(la), .any_pulse(aa));

  logic [26:0] obs;
  assign obs = {pm, lm, am, pl, ll, al, pa, la, aa};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: the input as seen after the synchronizer delay, and a
  // run-length filter per channel. Index 0 = re-arming, 1 = legacy one-shot.
  logic [SS-1:0] hist [NCH];
  int mode_m [2][NCH];
  int run_m  [2][NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      hist[c] = '0;
      for (int m = 0; m < 2; m++) begin
        mode_m[m][c] = M_REL;
        run_m[m][c]  = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      logic p;
      p = hist[c][SS-1];
      for (int m = 0; m < 2; m++) begin
        case (mode_m[m][c])
          M_REL: begin
            run_m[m][c] = p ? run_m[m][c] + 1 : 0;
            if (run_m[m][c] == DB + 1) begin
              mode_m[m][c] = M_PUL;
              run_m[m][c]  = 0;
            end
          end
          M_PUL: begin
            mode_m[m][c] = (m == 0) ? M_HELD : M_LOCK;
            run_m[m][c]  = 0;
          end
          M_HELD: begin
            run_m[m][c] = p ? 0 : run_m[m][c] + 1;
            if (run_m[m][c] == DB + 1) begin
              mode_m[m][c] = M_REL;
              run_m[m][c]  = 0;
            end
          end
          default: run_m[m][c] = 0;
        endcase
      end
      hist[c] = {hist[c][SS-2:0], prs[c]};
    end
  endtask

  function automatic logic [26:0] exp_vec();
    logic [NCH-1:0] p0, l0, p1, l1;
    for (int c = 0; c < NCH; c++) begin
      p0[c] = (mode_m[0][c] == M_PUL);
      l0[c] = (mode_m[0][c] == M_PUL) || (mode_m[0][c] == M_HELD);
      p1[c] = (mode_m[1][c] == M_PUL);
      l1[c] = (mode_m[1][c] == M_PUL) || (mode_m[1][c] == M_HELD);
    end
    return {p0, l0, |p0, p1, l1, |p1, p0, l0, |p0};
  endfunction

  // One clock: the model consumes the input the DUTs sampled at the rising
  // edge, then we move to the falling edge where outputs are compared and
  // new stimulus is applied.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    prs = '0;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (obs !== 27'd0) begin
        n_err++;
        $display("FAIL reset_outputs got=%h exp=%h", obs, 27'd0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_press();
    int pulse_edge, fall_edge, npulse, stray;
    logic seen_high;
    pulse_edge = -1; fall_edge = -1; npulse = 0; stray = 0; seen_high = 1'b0;
    prs[0] = 1'b1;
    for (int i = 1; i <= 85; i++) begin
      if (i == 41) prs[0] = 1'b0;
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL press_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (pm[0]) begin
        npulse++;
        if (pulse_edge < 0) pulse_edge = i - 1;
      end
      if (pm[3:1] != 0 || lm[3:1] != 0) stray++;
      if (lm[0]) seen_high = 1'b1;
      if (seen_high && !lm[0] && fall_edge < 0) fall_edge = i - 1;
    end
    n_chk++;
    if (pulse_edge !== LAT) begin
      n_err++;
      $display("FAIL press_latency got=%0d exp=%0d", pulse_edge, LAT);
    end
    n_chk++;
    if (npulse !== 1) begin
      n_err++;
      $display("FAIL press_pulse_count got=%0d exp=1", npulse);
    end
    n_chk++;
    if (fall_edge - 40 !== LAT) begin
      n_err++;
      $display("FAIL release_latency got=%0d exp=%0d", fall_edge - 40, LAT);
    end
    n_chk++;
    if (stray !== 0) begin
      n_err++;
      $display("FAIL press_other_channels got=%0d exp=0", stray);
    end
  endtask

  task automatic test_bounce();
    int pulse_edge, npulse;
    pulse_edge = -1; npulse = 0;
    for (int i = 1; i <= 120; i++) begin
      if (i <= 60) prs[1] = (((i - 1) / 5) % 2) == 0;
      else if (i <= 90) prs[1] = 1'b1;
      else prs[1] = 1'b0;
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL bounce_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (pm[1]) begin
        npulse++;
        if (pulse_edge < 0) pulse_edge = i - 1;
      end
    end
    n_chk++;
    if (npulse !== 1) begin
      n_err++;
      $display("FAIL bounce_pulse_count got=%0d exp=1", npulse);
    end
    n_chk++;
    if (pulse_edge - 60 !== LAT) begin
      n_err++;
      $display("FAIL bounce_latency got=%0d exp=%0d", pulse_edge - 60, LAT);
    end
  endtask

  task automatic test_release_bounce();
    int npulse, drops;
    npulse = 0; drops = 0;
    for (int i = 1; i <= 130; i++) begin
      prs[2] = (i <= 40) || (i > 46 && i <= 86);
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL relbounce_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (pm[2]) npulse++;
      if (i >= 20 && i <= 86 && !lm[2]) drops++;
    end
    n_chk++;
    if (npulse !== 1) begin
      n_err++;
      $display("FAIL relbounce_pulse_count got=%0d exp=1", npulse);
    end
    n_chk++;
    if (drops !== 0) begin
      n_err++;
      $display("FAIL relbounce_level_gap got=%0d exp=0", drops);
    end
  endtask

  task automatic test_rearm_legacy();
    int n_main, n_lg;
    do_reset();
    n_main = 0; n_lg = 0;
    for (int i = 0; i < 200; i++) begin
      prs[3] = (i < 180) && ((i % 60) < 30);
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL rearm_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (pm[3]) n_main++;
      if (pl[3]) n_lg++;
    end
    n_chk++;
    if (n_main !== 3) begin
      n_err++;
      $display("FAIL rearm_pulse_count got=%0d exp=3", n_main);
    end
    n_chk++;
    if (n_lg !== 1) begin
      n_err++;
      $display("FAIL legacy_pulse_count got=%0d exp=1", n_lg);
    end
    n_chk++;
    if (ll[3] !== 1'b0) begin
      n_err++;
      $display("FAIL legacy_level got=%b exp=0", ll[3]);
    end
    do_reset();
    n_lg = 0;
    for (int i = 0; i < 60; i++) begin
      prs[3] = (i < 30);
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL legacy_rst_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (pl[3]) n_lg++;
    end
    n_chk++;
    if (n_lg !== 1) begin
      n_err++;
      $display("FAIL legacy_after_rst got=%0d exp=1", n_lg);
    end
  endtask

  task automatic test_simultaneous();
    int hits, pulse_edge;
    logic [NCH-1:0] pv;
    logic any_v, ah_same;
    do_reset();
    hits = 0; pulse_edge = -1; pv = '0; any_v = 1'b0; ah_same = 1'b1;
    prs[0] = 1'b1;
    prs[2] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 31) prs = '0;
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL simul_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (pm != 0) begin
        hits++;
        pv = pm; any_v = am;
        if (pulse_edge < 0) pulse_edge = i - 1;
      end
      if (pa !== pm || aa !== am || la !== lm) ah_same = 1'b0;
    end
    n_chk++;
    if (pv !== 4'b0101 || any_v !== 1'b1) begin
      n_err++;
      $display("FAIL simul_vector got=%b/%b exp=0101/1", pv, any_v);
    end
    n_chk++;
    if (hits !== 1 || pulse_edge !== LAT) begin
      n_err++;
      $display("FAIL simul_timing got=%0d@%0d exp=1@%0d", hits, pulse_edge, LAT);
    end
    n_chk++;
    if (ah_same !== 1'b1) begin
      n_err++;
      $display("FAIL polarity_match got=%b exp=1", ah_same);
    end
  endtask

  task automatic test_async_reset();
    int pulse_edge;
    do_reset();
    pulse_edge = -1;
    prs[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL areset_pre t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
    end
    // Hold ch1 long enough that main is mid-level, then reset between edges.
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (obs !== 27'd0) begin
      n_err++;
      $display("FAIL areset_immediate got=%h exp=%h", obs, 27'd0);
    end
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL areset_post t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (pm[1] && pulse_edge < 0) pulse_edge = i - 1;
    end
    n_chk++;
    if (pulse_edge !== LAT) begin
      n_err++;
      $display("FAIL areset_latency got=%0d exp=%0d", pulse_edge, LAT);
    end
    prs = '0;
    for (int i = 0; i < 30; i++) tick();
  endtask

  task automatic test_random();
    int hold [NCH];
    int npulse;
    do_reset();
    npulse = 0;
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          prs[c] = ~prs[c];
          hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6))
                                                 : int'($urandom_range(15, 60));
        end else begin
          hold[c]--;
        end
      end
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL random_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
      end
      if (pm != 0) npulse++;
    end
    n_chk++;
    if (npulse == 0) begin
      n_err++;
      $display("FAIL random_activity got=%0d exp=>0", npulse);
    end
  endtask

  initial begin
    prs = '0;
    rst = 1'b1;
    model_reset();
    test_reset();
    test_press();
    test_bounce();
    test_release_bounce();
    test_rearm_legacy();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
